sblk_inst_sched: RTL
====================

# sblk_inst_sched

Instruction scheduler for a row of superblocks. It accepts a single host command stream and delivers each instruction to one superblock row or to all rows, pacing delivery on per-row busy status. It also provides a sync barrier that waits until every row is idle. It sits between the top-level controller and the superblock row, and drives that row's `inst_data`, `inst_en` and `status_sblk` pins directly.

## Interface
- `N_ROW`, 40, number of superblock rows served
- `WID_INST`, 14, instruction width (TN+TM+TP+LN+LP fields)
- `WID_ROW`, `$clog2(N_ROW)`, row index width
- `BUSY_LAT`, 2, cycles after issue during which a row is treated as busy regardless of `status_sblk` (min 1)

Ports:
- `clk_l`  in  1  the single clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_data`  in  WID_INST  instruction payload
- `cmd_row`  in  WID_ROW  target row (unicast only)
- `cmd_op`  in  2  00 unicast, 01 broadcast, 10 sync, 11 reserved
- `cmd_vld`  in  1  command valid
- `cmd_rdy`  out  1  command ready
- `inst_data`  out  WID_INST*N_ROW  per-row instruction, slice r = `[r*WID_INST +: WID_INST]`
- `inst_en`  out  N_ROW  one-cycle issue strobe per row
- `status_sblk`  in  N_ROW  1 = row busy
- `sync_done`  out  1  one-cycle pulse when a barrier completes
- `cmd_err`  out  1  one-cycle pulse for an illegal command
- `sched_busy`  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, UNI, BCAST, SYNC.
- `cmd_rdy` = 1 only in IDLE. A command is accepted when `cmd_vld & cmd_rdy`. Accepting latches `cmd_data`, `cmd_row` and `cmd_op`.
- Row free: `free[r] = !status_sblk[r] && holdoff[r]==0`.
- Each row has a holdoff counter of width `$clog2(BUSY_LAT+1)`. It loads BUSY_LAT on the edge that raises `inst_en[r]`, then decrements to 0 and saturates there.
- **IDLE** transitions on accept:
  - op 00 with `cmd_row<N_ROW` → UNI.
  - op 01 → BCAST, with pending mask set to all ones.
  - op 10 → SYNC.
  - op 11, or op 00 with `cmd_row>=N_ROW` → pulse `cmd_err` and stay in IDLE. The command is consumed and nothing is issued.
- **UNI**: waits until `free[row]`. It then registers `inst_en[row]=1` and `inst_data` slice row = payload, and goes to IDLE.
- **BCAST**: each cycle, every row with `pending[r] & free[r]` is issued in parallel and its pending bit is cleared. Several rows can be issued in one cycle. When the mask becomes zero (on the cycle of the final issue) → IDLE.
- **SYNC**: waits until `&free`, then pulses `sync_done` and goes to IDLE. It never asserts `inst_en`.
- `inst_data` slices are held registers. A slice changes only on an issue to that row, so unissued rows keep their previous value.
- `sched_busy` = (state != IDLE).

## Timing
- Reset: state = IDLE, pending = 0, holdoff = 0, `inst_en` = 0, `inst_data` = 0, `sync_done` = 0, `cmd_err` = 0, `sched_busy` = 0. `cmd_rdy` = 1 in the first cycle after reset.
- Reset mid-operation drops any in-flight command and pending broadcast rows. No `inst_en` is asserted in the cycle after `rst`.
- All outputs except `cmd_rdy` and `sched_busy` are registered.
- Unicast to a free row: accept at the end of cycle 0, UNI in cycle 1, `inst_en` high in cycle 2, `cmd_rdy` high in cycle 2. Sustained throughput is one unicast per 2 cycles.
- After issue in cycle 2, the row is not free in cycles 2..(1+BUSY_LAT). With BUSY_LAT=2 it is eligible again in cycle 4 if `status_sblk` is low.
- `status_sblk` is sampled combinationally in the wait states. A change that lands on the same cycle as an issue decision is honoured.
- Broadcast with all rows free: `inst_en` is all ones in cycle 2 and the FSM is back in IDLE in cycle 2.
- A sync accepted while all rows are free: `sync_done` high in cycle 2.
- No deadlock guarantee is given if a row never deasserts `status_sblk`. The FSM waits indefinitely and `sched_busy` stays high.

## Structure
- Shared package `sblk_pkg`: `cmd_op_e` enum (OP_UNI, OP_BCAST, OP_SYNC, OP_RSVD) and `sched_state_e`.
- One sub-module, `sblk_holdoff_cnt`: the per-row holdoff counter. It is instantiated N_ROW times in a generate loop and outputs `free`.

## Test plan
- Unicast `cmd_row=5`, `cmd_data=14'h1ABC`, all rows idle → `inst_en=1<<5` in cycle 2 only, slice 5 = 14'h1ABC, all other slices 0.
- Broadcast while rows 3 and 7 are held busy until cycle 10 → all other rows strobed in cycle 2, rows 3 and 7 strobed in cycle 11, IDLE afterwards, each row strobed exactly once.
- Back-to-back unicasts to row 2, `status_sblk[2]` low → strobes in cycles 2 and 5. The second strobe waits for holdoff; `cmd_rdy` is low while in UNI.
- Sync with row 39 busy until cycle 20 → `sync_done` pulses in cycle 21, with no `inst_en` activity.
- `cmd_row=45` unicast, then op 11 → `cmd_err` pulses for each, `inst_en` stays 0, and `cmd_rdy` returns high the next cycle.
- `rst` asserted in cycle 5 of a broadcast stalled on row 0 → all outputs 0 and IDLE from cycle 6, and row 0 is never strobed.

Source files
------------

// File: rtl/sblk_inst_sched_pkg.sv
// Shared types for the superblock instruction scheduler: host command opcodes and FSM states.
package sblk_pkg;

  typedef enum logic [1:0] {
    OP_UNI   = 2'b00,
    OP_BCAST = 2'b01,
    OP_SYNC  = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StUni,
    StBcast,
    StSync
  } sched_state_e;

endpackage

// File: rtl/sblk_inst_sched_if.sv
// Host command channel into the scheduler: payload, target row, opcode, valid/ready.
interface sblk_inst_sched_if
  import sblk_pkg::*;
#(
  parameter int unsigned WID_INST = 14,
  parameter int unsigned WID_ROW  = 6
);

  logic [WID_INST-1:0] cmd_data;
  logic [WID_ROW-1:0]  cmd_row;
  cmd_op_e             cmd_op;
  logic                cmd_vld;
  logic                cmd_rdy;

  modport master (
    output cmd_data,
    output cmd_row,
    output cmd_op,
    output cmd_vld,
    input  cmd_rdy
  );

  modport slave (
    input  cmd_data,
    input  cmd_row,
    input  cmd_op,
    input  cmd_vld,
    output cmd_rdy
  );

endinterface

// File: rtl/sblk_inst_sched_holdoff.sv
// Per-row holdoff: masks a row as busy for BUSY_LAT cycles after an issue, before the
// row's own status_sblk has had time to rise.
module sblk_holdoff_cnt #(
  parameter int unsigned BUSY_LAT = 2
) (
  input  logic clk_l,
  input  logic rst,
  input  logic load,
  input  logic busy,
  output logic free
);

  localparam int unsigned CntW = (BUSY_LAT < 1) ? 1 : $clog2(BUSY_LAT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_l) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(BUSY_LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign free = !busy && (cnt_q == '0);

endmodule

// File: rtl/sblk_inst_sched.sv
// Instruction scheduler: takes one host command stream and issues unicast/broadcast
// instructions to a row of superblocks, paced on per-row busy; also provides a sync barrier.
module sblk_inst_sched
  import sblk_pkg::*;
#(
  parameter int unsigned N_ROW    = 40,
  parameter int unsigned WID_INST = 14,
  parameter int unsigned WID_ROW  = $clog2(N_ROW),
  parameter int unsigned BUSY_LAT = 2
) (
  input  logic                      clk_l,
  input  logic                      rst,
  sblk_inst_sched_if.slave          cmd,
  output logic [WID_INST*N_ROW-1:0] inst_data,
  output logic [N_ROW-1:0]          inst_en,
  input  logic [N_ROW-1:0]          status_sblk,
  output logic                      sync_done,
  output logic                      cmd_err,
  output logic                      sched_busy
);

  localparam logic [WID_ROW-1:0] LastRow = WID_ROW'(N_ROW - 1);

  sched_state_e                state_q;
  logic [WID_ROW-1:0]          row_q;
  logic [WID_INST-1:0]         data_q;
  logic [N_ROW-1:0]            pending_q;
  logic [N_ROW-1:0]            inst_en_q;
  logic [WID_INST*N_ROW-1:0]   inst_data_q;
  logic                        sync_done_q;
  logic                        cmd_err_q;

  logic [N_ROW-1:0] free;
  logic [N_ROW-1:0] issue;
  logic [N_ROW-1:0] row_sel;
  logic             accept;
  logic             row_ok;

  for (genvar r = 0; r < N_ROW; r++) begin : g_holdoff
    sblk_holdoff_cnt #(
      .BUSY_LAT(BUSY_LAT)
    ) u_holdoff (
      .clk_l(clk_l),
      .rst  (rst),
      .load (issue[r]),
      .busy (status_sblk[r]),
      .free (free[r])
    );
  end

  assign cmd.cmd_rdy = (state_q == StIdle);
  assign accept      = cmd.cmd_vld && cmd.cmd_rdy;
  assign row_ok      = (cmd.cmd_row <= LastRow);
  assign row_sel     = {{(N_ROW-1){1'b0}}, 1'b1} << row_q;

  // Issue decision uses live status_sblk, so a release on the decision cycle is honoured.
  always_comb begin
    issue = '0;
    unique case (state_q)
      StUni:   issue = row_sel & free;
      StBcast: issue = pending_q & free;
      default: issue = '0;
    endcase
  end

  always_ff @(posedge clk_l) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      data_q      <= '0;
      pending_q   <= '0;
      inst_en_q   <= '0;
      inst_data_q <= '0;
      sync_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      inst_en_q   <= issue;
      sync_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      for (int r = 0; r < N_ROW; r++) begin
        if (issue[r]) inst_data_q[r*WID_INST +: WID_INST] <= data_q;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data_q <= cmd.cmd_data;
            row_q  <= cmd.cmd_row;
            case (cmd.cmd_op)
              OP_UNI: begin
                if (row_ok) state_q <= StUni;
                else        cmd_err_q <= 1'b1;
              end
              OP_BCAST: begin
                pending_q <= '1;
                state_q   <= StBcast;
              end
              OP_SYNC: state_q   <= StSync;
              default: cmd_err_q <= 1'b1;
            endcase
          end
        end
        StUni: begin
          if (|issue) state_q <= StIdle;
        end
        StBcast: begin
          pending_q <= pending_q & ~issue;
          if ((pending_q & ~issue) == '0) state_q <= StIdle;
        end
        StSync: begin
          if (&free) begin
            sync_done_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign inst_en    = inst_en_q;
  assign inst_data  = inst_data_q;
  assign sync_done  = sync_done_q;
  assign cmd_err    = cmd_err_q;
  assign sched_busy = (state_q != StIdle);

endmodule
